// File: rtl/ex_result_pipe.sv
// ex_result_pipe: EX/MEM and MEM/WB result registers with a single-outstanding data-memory handshake and forwarding taps.
module ex_result_pipe #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_EX,
    input  logic              flush_EX,
    input  logic [DATA_W-1:0] ALUOutput_EX,
    input  logic [DATA_W-1:0] RegOut2_EX,
    input  logic [4:0]        Rd_EX,
    input  logic              RegWrite_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_EX,
    output logic              fwd_valid_MEM,
    output logic [4:0]        fwd_Rd_MEM,
    output logic [DATA_W-1:0] fwd_data_MEM,
    output logic              load_pending_MEM,
    output logic              RegWrite_WB,
    output logic [4:0]        Rd_WB,
    output logic [DATA_W-1:0] WriteData_WB
);
    typedef enum logic [1:0] {MEM_EMPTY, MEM_ALU, MEM_WAIT} state_t;
    state_t state, state_next;
    logic [DATA_W-1:0] addr_mem, data_mem;
    logic [4:0] rd_mem;
    logic we_mem, load_mem, store_mem;
    logic advance, capture_valid, wb_we;
    always_ff @(posedge clk)
        if (!rst_n) state <= MEM_EMPTY;
        else state <= state_next;
    always_comb begin
        capture_valid = valid_EX & ~flush_EX;
        advance = ~stall_EX;
        state_next = !advance ? state :
                     !capture_valid ? MEM_EMPTY :
                     (MemRead_EX | MemWrite_EX) ? MEM_WAIT : MEM_ALU;
        wb_we = advance & (state != MEM_EMPTY) & we_mem;
    end
    always_comb begin
        mem_req = state == MEM_WAIT;
        mem_we = mem_req & store_mem;
        mem_addr = addr_mem;
        mem_wdata = data_mem;
        stall_EX = mem_req & ~mem_ready;
        fwd_valid_MEM = (state == MEM_ALU) & we_mem;
        fwd_Rd_MEM = rd_mem;
        fwd_data_MEM = addr_mem;
        load_pending_MEM = mem_req & load_mem;
    end
    // a store with MemRead also set is still a store, and never writes a register
    always_ff @(posedge clk)
        if (!rst_n) begin
            addr_mem <= '0;
            data_mem <= '0;
            rd_mem <= '0;
            we_mem <= 1'b0;
            load_mem <= 1'b0;
            store_mem <= 1'b0;
        end else if (advance) begin
            addr_mem <= ALUOutput_EX;
            data_mem <= RegOut2_EX;
            rd_mem <= Rd_EX;
            we_mem <= capture_valid & RegWrite_EX & ~MemWrite_EX & (Rd_EX != 5'd31);
            load_mem <= capture_valid & MemRead_EX & ~MemWrite_EX;
            store_mem <= capture_valid & MemWrite_EX;
        end
    always_ff @(posedge clk)
        if (!rst_n) begin
            RegWrite_WB <= 1'b0;
            Rd_WB <= '0;
            WriteData_WB <= '0;
        end else begin
            RegWrite_WB <= wb_we;
            if (wb_we) begin
                Rd_WB <= rd_mem;
                WriteData_WB <= state == MEM_WAIT ? mem_rdata : addr_mem;
            end
        end
endmodule

// File: tb/tb_ex_result_pipe.sv
// tb_ex_result_pipe: directed scenarios plus a randomized run against a transaction-level slot model.
module tb_ex_result_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    logic valid_EX, flush_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, mem_ready;
    logic [63:0] ALUOutput_EX, RegOut2_EX, mem_rdata;
    logic [4:0] Rd_EX;
    logic mem_req, mem_we, stall_EX, fwd_valid_MEM, load_pending_MEM, RegWrite_WB;
    logic [63:0] mem_addr, mem_wdata, fwd_data_MEM, WriteData_WB;
    logic [4:0] fwd_Rd_MEM, Rd_WB;
    int tests = 0, fails = 0;

    ex_result_pipe #(.DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .flush_EX(flush_EX),
        .ALUOutput_EX(ALUOutput_EX), .RegOut2_EX(RegOut2_EX), .Rd_EX(Rd_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_EX(stall_EX),
        .fwd_valid_MEM(fwd_valid_MEM), .fwd_Rd_MEM(fwd_Rd_MEM), .fwd_data_MEM(fwd_data_MEM),
        .load_pending_MEM(load_pending_MEM), .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB),
        .WriteData_WB(WriteData_WB)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        valid_EX = 0; flush_EX = 0; RegWrite_EX = 0; MemRead_EX = 0; MemWrite_EX = 0;
        ALUOutput_EX = 0; RegOut2_EX = 0; Rd_EX = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] st,
                            input logic rw, input logic mr, input logic mw);
        valid_EX = 1; flush_EX = 0; Rd_EX = rd; ALUOutput_EX = alu; RegOut2_EX = st;
        RegWrite_EX = rw; MemRead_EX = mr; MemWrite_EX = mw;
    endtask

    task automatic test_reset;
        logic [271:0] o;
        rst_n = 0;
        drive_ex(5'd12, 64'hFFFF_0000_AAAA_5555, 64'h1357, 1, 1, 0);
        mem_ready = 1; mem_rdata = 64'h2468;
        tick; tick;
        #2;
        o = {mem_req, mem_we, mem_addr, mem_wdata, stall_EX, fwd_valid_MEM, fwd_Rd_MEM, fwd_data_MEM,
             load_pending_MEM, RegWrite_WB, Rd_WB, WriteData_WB};
        tests++; if (o !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", o); end
        idle;
        rst_n = 1;
        tick; tick;
        #2;
        o = {mem_req, mem_we, mem_addr, mem_wdata, stall_EX, fwd_valid_MEM, fwd_Rd_MEM, fwd_data_MEM,
             load_pending_MEM, RegWrite_WB, Rd_WB, WriteData_WB};
        tests++; if (o !== '0) begin fails++; $display("FAIL reset_idle_outputs: got %h want 0", o); end
    endtask

    task automatic test_alu;
        drive_ex(5'd5, 64'h1234, 64'h9999, 1, 0, 0);
        tick;
        idle;
        #2;
        tests++; if (fwd_valid_MEM !== 1'b1) begin fails++; $display("FAIL alu_fwd_valid: got %0b want 1", fwd_valid_MEM); end
        tests++; if (fwd_data_MEM !== 64'h1234) begin fails++; $display("FAIL alu_fwd_data: got %h want 1234", fwd_data_MEM); end
        tests++; if (fwd_Rd_MEM !== 5'd5) begin fails++; $display("FAIL alu_fwd_rd: got %0d want 5", fwd_Rd_MEM); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL alu_no_req: got %0b want 0", mem_req); end
        tick;
        #2;
        tests++; if ({RegWrite_WB, Rd_WB, WriteData_WB} !== {1'b1, 5'd5, 64'h1234}) begin
            fails++; $display("FAIL alu_wb: got we=%0b rd=%0d data=%h want we=1 rd=5 data=1234", RegWrite_WB, Rd_WB, WriteData_WB);
        end
        tests++; if (fwd_valid_MEM !== 1'b0) begin fails++; $display("FAIL alu_fwd_clear: got %0b want 0", fwd_valid_MEM); end
    endtask

    task automatic test_load_wait;
        drive_ex(5'd7, 64'h100, 64'h0, 1, 1, 0);
        tick;
        idle;
        for (int c = 1; c <= 3; c++) begin
            mem_ready = (c == 3);
            mem_rdata = (c == 3) ? 64'hDEAD : 64'h0BAD;
            #2;
            tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h100}) begin
                fails++; $display("FAIL load_req_c%0d: got req=%0b we=%0b addr=%h want req=1 we=0 addr=100", c, mem_req, mem_we, mem_addr);
            end
            tests++; if (stall_EX !== (c != 3)) begin fails++; $display("FAIL load_stall_c%0d: got %0b want %0b", c, stall_EX, c != 3); end
            tests++; if (load_pending_MEM !== 1'b1) begin fails++; $display("FAIL load_pending_c%0d: got %0b want 1", c, load_pending_MEM); end
            tests++; if (RegWrite_WB !== 1'b0) begin fails++; $display("FAIL load_wb_quiet_c%0d: got %0b want 0", c, RegWrite_WB); end
            tick;
        end
        mem_ready = 0;
        #2;
        tests++; if ({RegWrite_WB, Rd_WB, WriteData_WB} !== {1'b1, 5'd7, 64'hDEAD}) begin
            fails++; $display("FAIL load_wb: got we=%0b rd=%0d data=%h want we=1 rd=7 data=dead", RegWrite_WB, Rd_WB, WriteData_WB);
        end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL load_req_drop: got %0b want 0", mem_req); end
    endtask

    task automatic test_back_to_back;
        drive_ex(5'd3, 64'h200, 64'hCAFE, 1, 0, 1);
        tick;
        drive_ex(5'd9, 64'h208, 64'h0, 1, 1, 0);
        mem_ready = 1;
        #2;
        tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 64'h200, 64'hCAFE}) begin
            fails++; $display("FAIL b2b_store_req: got req=%0b we=%0b addr=%h wdata=%h want 1 1 200 cafe", mem_req, mem_we, mem_addr, mem_wdata);
        end
        tests++; if (stall_EX !== 1'b0) begin fails++; $display("FAIL b2b_store_stall: got %0b want 0", stall_EX); end
        tick;
        idle;
        mem_ready = 1; mem_rdata = 64'hBEEF;
        #2;
        tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h208}) begin
            fails++; $display("FAIL b2b_load_req: got req=%0b we=%0b addr=%h want 1 0 208", mem_req, mem_we, mem_addr);
        end
        tests++; if (RegWrite_WB !== 1'b0) begin fails++; $display("FAIL b2b_store_wb: got %0b want 0", RegWrite_WB); end
        tick;
        mem_ready = 0;
        #2;
        tests++; if ({mem_req, RegWrite_WB, Rd_WB, WriteData_WB} !== {1'b0, 1'b1, 5'd9, 64'hBEEF}) begin
            fails++; $display("FAIL b2b_load_wb: got req=%0b we=%0b rd=%0d data=%h want 0 1 9 beef", mem_req, RegWrite_WB, Rd_WB, WriteData_WB);
        end
    endtask

    task automatic test_xzr_flush;
        drive_ex(5'd31, 64'h55, 64'h0, 1, 0, 0);
        tick;
        idle;
        #2;
        tests++; if (fwd_valid_MEM !== 1'b0) begin fails++; $display("FAIL xzr_fwd: got %0b want 0", fwd_valid_MEM); end
        tick;
        #2;
        tests++; if (RegWrite_WB !== 1'b0) begin fails++; $display("FAIL xzr_wb: got %0b want 0", RegWrite_WB); end
        drive_ex(5'd4, 64'h66, 64'h0, 1, 0, 0);
        flush_EX = 1;
        tick;
        idle;
        #2;
        tests++; if ({fwd_valid_MEM, load_pending_MEM, mem_req} !== 3'b000) begin
            fails++; $display("FAIL flush_mem: got fwd=%0b lp=%0b req=%0b want 0 0 0", fwd_valid_MEM, load_pending_MEM, mem_req);
        end
        tick;
        #2;
        tests++; if (RegWrite_WB !== 1'b0) begin fails++; $display("FAIL flush_wb: got %0b want 0", RegWrite_WB); end
    endtask

    task automatic test_reset_wait;
        drive_ex(5'd6, 64'h300, 64'h0, 1, 1, 0);
        tick;
        idle;
        #2;
        tests++; if ({mem_req, stall_EX} !== 2'b11) begin fails++; $display("FAIL rstwait_pre: got req=%0b stall=%0b want 1 1", mem_req, stall_EX); end
        rst_n = 0;
        tick;
        rst_n = 1;
        #2;
        tests++; if ({mem_req, stall_EX, RegWrite_WB} !== 3'b000) begin
            fails++; $display("FAIL rstwait_post: got req=%0b stall=%0b we=%0b want 0 0 0", mem_req, stall_EX, RegWrite_WB);
        end
        mem_ready = 1; mem_rdata = 64'h77;
        tick;
        mem_ready = 0;
        #2;
        tests++; if ({mem_req, RegWrite_WB} !== 2'b00) begin fails++; $display("FAIL rstwait_after: got req=%0b we=%0b want 0 0", mem_req, RegWrite_WB); end
    endtask

    // model: kind 0 = nothing, 1 = ALU op, 2 = load, 3 = store sitting in MEM
    int m_kind;
    logic m_we, w_we;
    logic [4:0] m_rd, w_rd;
    logic [63:0] m_addr, m_data, w_data;

    task automatic test_random;
        logic e_stall, held;
        idle;
        rst_n = 0;
        tick;
        rst_n = 1;
        m_kind = 0; m_we = 0; m_rd = 0; m_addr = 0; m_data = 0; w_we = 0; w_rd = 0; w_data = 0;
        held = 0;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!held) begin
                valid_EX = ($urandom_range(0, 4) != 0);
                Rd_EX = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                ALUOutput_EX = {$urandom, $urandom};
                RegOut2_EX = {$urandom, $urandom};
                RegWrite_EX = ($urandom_range(0, 3) != 0);
                MemRead_EX = ($urandom_range(0, 2) == 0);
                MemWrite_EX = ($urandom_range(0, 3) == 0);
            end
            flush_EX = ($urandom_range(0, 6) == 0);
            mem_ready = ($urandom_range(0, 4) < 2);
            mem_rdata = {$urandom, $urandom};
            #2;
            e_stall = (m_kind >= 2) && !mem_ready;
            tests++; if (mem_req !== (m_kind >= 2)) begin fails++; $display("FAIL rnd_req@%0d: got %0b want %0b", n, mem_req, m_kind >= 2); end
            tests++; if (mem_we !== (m_kind == 3)) begin fails++; $display("FAIL rnd_we@%0d: got %0b want %0b", n, mem_we, m_kind == 3); end
            tests++; if (stall_EX !== e_stall) begin fails++; $display("FAIL rnd_stall@%0d: got %0b want %0b", n, stall_EX, e_stall); end
            tests++; if (load_pending_MEM !== (m_kind == 2)) begin fails++; $display("FAIL rnd_lp@%0d: got %0b want %0b", n, load_pending_MEM, m_kind == 2); end
            tests++; if (fwd_valid_MEM !== (m_kind == 1 && m_we)) begin fails++; $display("FAIL rnd_fwd@%0d: got %0b want %0b", n, fwd_valid_MEM, m_kind == 1 && m_we); end
            tests++; if (RegWrite_WB !== w_we) begin fails++; $display("FAIL rnd_wb_we@%0d: got %0b want %0b", n, RegWrite_WB, w_we); end
            if (m_kind >= 2) begin
                tests++; if ({mem_addr, mem_wdata} !== {m_addr, m_data}) begin
                    fails++; $display("FAIL rnd_req_data@%0d: got addr=%h wdata=%h want addr=%h wdata=%h", n, mem_addr, mem_wdata, m_addr, m_data);
                end
            end
            if (m_kind == 1) begin
                tests++; if ({fwd_Rd_MEM, fwd_data_MEM} !== {m_rd, m_addr}) begin
                    fails++; $display("FAIL rnd_fwd_data@%0d: got rd=%0d data=%h want rd=%0d data=%h", n, fwd_Rd_MEM, fwd_data_MEM, m_rd, m_addr);
                end
            end
            if (w_we) begin
                tests++; if ({Rd_WB, WriteData_WB} !== {w_rd, w_data}) begin
                    fails++; $display("FAIL rnd_wb_data@%0d: got rd=%0d data=%h want rd=%0d data=%h", n, Rd_WB, WriteData_WB, w_rd, w_data);
                end
            end
            if (!rst_n) begin
                m_kind = 0; m_we = 0; w_we = 0; w_rd = 0; w_data = 0;
            end else if (e_stall) begin
                w_we = 0;
            end else begin
                w_we = (m_kind == 1 || m_kind == 2) && m_we;
                if (w_we) begin
                    w_rd = m_rd;
                    w_data = (m_kind == 2) ? mem_rdata : m_addr;
                end
                m_kind = (!valid_EX || flush_EX) ? 0 : MemWrite_EX ? 3 : MemRead_EX ? 2 : 1;
                m_we = RegWrite_EX && Rd_EX != 5'd31 && m_kind != 3 && m_kind != 0;
                m_rd = Rd_EX; m_addr = ALUOutput_EX; m_data = RegOut2_EX;
            end
            held = rst_n && e_stall;
            tick;
        end
        rst_n = 1;
        idle;
    endtask

    initial begin
        idle;
        test_reset;
        test_alu;
        test_load_wait;
        test_back_to_back;
        test_xzr_flush;
        test_reset_wait;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
